// File: rtl/lcd_ctrl.sv
// lcd_ctrl: write-only character-LCD strobe sequencer fed from a 32-bit core register.
// Define LCD_CTRL_PENDING_EN to add a one-entry request buffer; otherwise busy-time requests are dropped.
module lcd_ctrl #(
    parameter int SETUP_CYC     = 3,
    parameter int PULSE_CYC     = 12,
    parameter int HOLD_CYC      = 3,
    parameter int EXEC_CYC      = 1850,
    parameter int EXEC_LONG_CYC = 76000
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic [31:0] i_lcd_word,
    output logic [7:0]  o_lcd_data,
    output logic        o_lcd_rs,
    output logic        o_lcd_rw,
    output logic        o_lcd_en,
    output logic        o_lcd_on,
    output logic        o_busy,
    output logic        o_overrun
);
    localparam int MAX_SP  = (SETUP_CYC > PULSE_CYC) ? SETUP_CYC : PULSE_CYC;
    localparam int MAX_SPH = (MAX_SP > HOLD_CYC) ? MAX_SP : HOLD_CYC;
    localparam int MAX_EX  = (EXEC_CYC > EXEC_LONG_CYC) ? EXEC_CYC : EXEC_LONG_CYC;
    localparam int MAX_CYC = (MAX_SPH > MAX_EX) ? MAX_SPH : MAX_EX;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);

    typedef logic [CNT_W-1:0] cnt_t;
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_PULSE,
        ST_HOLD,
        ST_WAIT
    } state_t;

    state_t     state_q, state_d;
    cnt_t       cnt_q, cnt_d;
    logic [7:0] data_q, data_d;
    logic       rs_q, rs_d;
    logic       en_q, en_d;
    logic       on_q, on_d;
    logic       busy_q, busy_d;
    logic       ovr_q, ovr_d;
    logic       go_q, go_d;
    logic       arm_q, arm_d;
    logic       req;
    logic       long_cmd;
`ifdef LCD_CTRL_PENDING_EN
    logic       pend_vld_q, pend_vld_d;
    logic       pend_rs_q, pend_rs_d;
    logic [7:0] pend_data_q, pend_data_d;
`endif

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        data_d   = data_q;
        rs_d     = rs_q;
        ovr_d    = ovr_q;
        go_d     = i_lcd_word[10];
        on_d     = i_lcd_word[31];
        // GO must be seen low once after reset, so a level left high across reset is not a request
        arm_d    = arm_q | ~i_lcd_word[10];
        req      = i_lcd_word[10] & ~go_q & arm_q;
        long_cmd = ~rs_q && ((data_q == 8'h01) || (data_q == 8'h02) || (data_q == 8'h03));
`ifdef LCD_CTRL_PENDING_EN
        pend_vld_d  = pend_vld_q;
        pend_rs_d   = pend_rs_q;
        pend_data_d = pend_data_q;
`endif

        case (state_q)
            ST_IDLE: begin
`ifdef LCD_CTRL_PENDING_EN
                if (pend_vld_q) begin
                    state_d    = ST_SETUP;
                    cnt_d      = cnt_t'(SETUP_CYC - 1);
                    rs_d       = pend_rs_q;
                    data_d     = pend_data_q;
                    pend_vld_d = req;
                    if (req) begin
                        pend_rs_d   = i_lcd_word[9];
                        pend_data_d = i_lcd_word[7:0];
                    end
                end else
`endif
                if (req) begin
                    state_d = ST_SETUP;
                    cnt_d   = cnt_t'(SETUP_CYC - 1);
                    rs_d    = i_lcd_word[9];
                    data_d  = i_lcd_word[7:0];
                end
            end
            ST_SETUP: begin
                if (cnt_q == '0) begin
                    state_d = ST_PULSE;
                    cnt_d   = cnt_t'(PULSE_CYC - 1);
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_PULSE: begin
                if (cnt_q == '0) begin
                    state_d = ST_HOLD;
                    cnt_d   = cnt_t'(HOLD_CYC - 1);
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_HOLD: begin
                if (cnt_q == '0) begin
                    state_d = ST_WAIT;
                    cnt_d   = long_cmd ? cnt_t'(EXEC_LONG_CYC - 1) : cnt_t'(EXEC_CYC - 1);
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_WAIT: begin
                if (cnt_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase

        if (req && (state_q != ST_IDLE)) begin
`ifdef LCD_CTRL_PENDING_EN
            if (!pend_vld_q) begin
                pend_vld_d  = 1'b1;
                pend_rs_d   = i_lcd_word[9];
                pend_data_d = i_lcd_word[7:0];
            end else begin
                ovr_d = 1'b1;
            end
`else
            ovr_d = 1'b1;
`endif
        end

        en_d   = (state_d == ST_PULSE);
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            data_q  <= 8'h00;
            rs_q    <= 1'b0;
            en_q    <= 1'b0;
            on_q    <= 1'b0;
            busy_q  <= 1'b0;
            ovr_q   <= 1'b0;
            go_q    <= 1'b0;
            arm_q   <= 1'b0;
`ifdef LCD_CTRL_PENDING_EN
            pend_vld_q  <= 1'b0;
            pend_rs_q   <= 1'b0;
            pend_data_q <= 8'h00;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            rs_q    <= rs_d;
            en_q    <= en_d;
            on_q    <= on_d;
            busy_q  <= busy_d;
            ovr_q   <= ovr_d;
            go_q    <= go_d;
            arm_q   <= arm_d;
`ifdef LCD_CTRL_PENDING_EN
            pend_vld_q  <= pend_vld_d;
            pend_rs_q   <= pend_rs_d;
            pend_data_q <= pend_data_d;
`endif
        end
    end

    assign o_lcd_data = data_q;
    assign o_lcd_rs   = rs_q;
    assign o_lcd_rw   = 1'b0;
    assign o_lcd_en   = en_q;
    assign o_lcd_on   = on_q;
    assign o_busy     = busy_q;
    assign o_overrun  = ovr_q;

endmodule
